// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer slice.
// Holds the opcode constants, result-select encodings, the sequencer
// state enum and the bit positions of the instruction fields.
package cpu_ctrl_pkg;

  // Opcodes in instr[15:12]; 7..E are undefined
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_MOV  = 4'h5;
  localparam logic [3:0] OP_ADC  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Result-select encodings driven on rec
  localparam logic [1:0] REC_ARITH = 2'b00;
  localparam logic [1:0] REC_AND   = 2'b01;
  localparam logic [1:0] REC_OR    = 2'b10;
  localparam logic [1:0] REC_PASS  = 2'b11;

  // Instruction field bit positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder for the control sequencer.
// Ports:
//   opcode     - instruction opcode (IR[15:12])
//   carry_flag - ALU carry flag, forwarded to cin for ADC
//   cin        - ALU carry-in for this opcode
//   rec        - result select for this opcode
//   wr         - opcode writes the register file
//   illegal    - opcode is undefined (7..E)
//   halt       - opcode is HALT
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  output logic       cin,
  output logic [1:0] rec,
  output logic       wr,
  output logic       illegal,
  output logic       halt
);

  // Undefined opcodes decode as NOP apart from raising illegal
  always_comb begin
    cin     = 1'b0;
    rec     = REC_ARITH;
    wr      = 1'b0;
    illegal = 1'b0;
    halt    = 1'b0;
    case (opcode)
      OP_NOP: begin
        wr = 1'b0;
      end
      OP_ADD: begin
        wr = 1'b1;
      end
      OP_SUB: begin
        cin = 1'b1;
        wr  = 1'b1;
      end
      OP_AND: begin
        rec = REC_AND;
        wr  = 1'b1;
      end
      OP_OR: begin
        rec = REC_OR;
        wr  = 1'b1;
      end
      OP_MOV: begin
        rec = REC_PASS;
        wr  = 1'b1;
      end
      OP_ADC: begin
        cin = carry_flag;
        wr  = 1'b1;
      end
      OP_HALT: begin
        halt = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer feeding the control-capture register.
// Accepts instructions over a valid/ready handshake and steps each one
// through FETCH -> DECODE -> EXEC -> WB, driving register selects,
// carry-in, result select and one-cycle PC / register-write pulses.
// Ports:
//   clk, reset        - clock; asynchronous active-low reset
//   run               - permits fetching new instructions
//   instr/instr_valid - instruction word and its valid flag
//   instr_ready       - high in FETCH (instruction accepted on valid)
//   carry_flag        - ALU carry, sampled in DECODE for ADC
//   input_a/b/c       - source A, source B, destination selects
//   cin, rec          - ALU carry-in and result select
//   pc_en, reg_en     - one-cycle pulses in WB
//   busy, halted      - in DECODE/EXEC/WB; in HALT
//   illegal           - sticky undefined-opcode flag
//   instr_count       - retired instruction count (wraps)
module ctrl_seq
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             carry_flag,
  output logic [2:0]       input_a,
  output logic [2:0]       input_b,
  output logic [2:0]       input_c,
  output logic             cin,
  output logic [1:0]       rec,
  output logic             pc_en,
  output logic             reg_en,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;
  logic        wr_q;

  logic        dec_cin;
  logic [1:0]  dec_rec;
  logic        dec_wr;
  logic        dec_illegal;
  logic        dec_halt;

  logic        nxt_ready;
  logic        nxt_busy;
  logic        nxt_halted;
  logic        nxt_wb;

  logic        unused_ir_bits;

  assign unused_ir_bits = ^ir[2:0];

  ctrl_decode u_decode (
    .opcode     (ir[OPC_MSB:OPC_LSB]),
    .carry_flag (carry_flag),
    .cin        (dec_cin),
    .rec        (dec_rec),
    .wr         (dec_wr),
    .illegal    (dec_illegal),
    .halt       (dec_halt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus the next values of the status outputs. Status outputs
  // are registered from next_state so they line up with the state itself.
  // A handshake in FETCH wins over run being dropped in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (run) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (instr_valid)  next_state = ST_DECODE;
        else if (!run)    next_state = ST_IDLE;
      end
      ST_DECODE: begin
        next_state = dec_halt ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        next_state = ST_WB;
      end
      ST_WB: begin
        next_state = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        next_state = ST_HALT;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    nxt_ready  = (next_state == ST_FETCH);
    nxt_busy   = (next_state == ST_DECODE) || (next_state == ST_EXEC) ||
                 (next_state == ST_WB);
    nxt_halted = (next_state == ST_HALT);
    nxt_wb     = (next_state == ST_WB);
  end

  // Registered outputs, IR and counter. Field outputs load at the end of
  // DECODE and then hold until the next DECODE. wr_q remembers whether the
  // decoded opcode writes so reg_en can pulse two cycles later in WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir          <= '0;
      wr_q        <= 1'b0;
      instr_ready <= 1'b0;
      input_a     <= '0;
      input_b     <= '0;
      input_c     <= '0;
      cin         <= 1'b0;
      rec         <= REC_ARITH;
      pc_en       <= 1'b0;
      reg_en      <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      instr_ready <= nxt_ready;
      busy        <= nxt_busy;
      halted      <= nxt_halted;
      pc_en       <= nxt_wb;
      reg_en      <= nxt_wb && wr_q;

      if (state == ST_FETCH && instr_valid) begin
        ir <= instr;
      end

      if (state == ST_DECODE) begin
        input_a <= ir[RA_MSB:RA_LSB];
        input_b <= ir[RB_MSB:RB_LSB];
        input_c <= ir[RD_MSB:RD_LSB];
        cin     <= dec_cin;
        rec     <= dec_rec;
        wr_q    <= dec_wr;
        if (dec_illegal) illegal <= 1'b1;
      end

      if (nxt_wb) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule
